// File: rtl/axis_scaler_pkg.sv
// -----------------------------------------------------------------------------
// axis_scaler_pkg
// Shared definitions for the axis_scaler frame controller:
//   - scaler_ctl_state_t : controller FSM encoding (IDLE=0, WAIT_SYNC=1, RUN=2)
//   - C_*_WIDTH_DEF      : default port widths
//   - ERR_*              : bit positions inside the sticky error vector
// -----------------------------------------------------------------------------
package axis_scaler_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_SYNC = 2'd1,
    RUN       = 2'd2
  } scaler_ctl_state_t;

  localparam int unsigned C_SH_WIDTH_DEF      = 32'd12;
  localparam int unsigned C_SW_WIDTH_DEF      = 32'd12;
  localparam int unsigned C_MH_WIDTH_DEF      = 32'd12;
  localparam int unsigned C_MW_WIDTH_DEF      = 32'd12;
  localparam int unsigned C_FRMCNT_WIDTH_DEF  = 32'd16;
  localparam int unsigned C_TIMEOUT_WIDTH_DEF = 32'd24;

  // Sticky error vector layout
  localparam int unsigned ERR_SOF     = 32'd0;
  localparam int unsigned ERR_EOL     = 32'd1;
  localparam int unsigned ERR_OVERRUN = 32'd2;
  localparam int unsigned ERR_TIMEOUT = 32'd3;
  localparam int unsigned ERR_CFG     = 32'd4;
  localparam int unsigned ERR_NUM     = 32'd5;

endpackage

// File: rtl/axis_frame_checker.sv
// -----------------------------------------------------------------------------
// axis_frame_checker
// Tracks the row/column position of the scaler output stream and checks the
// SOF (tuser) and EOL (tlast) framing on every accepted beat.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   start               : clear row/col (frame is being applied)
//   beat                : accepted beat while the controller is in RUN
//   tuser, tlast        : sideband of the monitored stream
//   m_height, m_width   : active output geometry
//   frame_last          : strobe, this beat is the last one of the frame
//   sof_err, eol_err    : strobes, framing mismatch on this beat
// -----------------------------------------------------------------------------
module axis_frame_checker #(
  parameter int unsigned C_MH_WIDTH = 32'd12,
  parameter int unsigned C_MW_WIDTH = 32'd12
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  beat,
  input  logic                  tuser,
  input  logic                  tlast,
  input  logic [C_MH_WIDTH-1:0] m_height,
  input  logic [C_MW_WIDTH-1:0] m_width,
  output logic                  frame_last,
  output logic                  sof_err,
  output logic                  eol_err
);

  localparam logic [C_MH_WIDTH-1:0] MH_ONE  = {{(C_MH_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [C_MW_WIDTH-1:0] MW_ONE  = {{(C_MW_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [C_MH_WIDTH-1:0] MH_ZERO = {C_MH_WIDTH{1'b0}};
  localparam logic [C_MW_WIDTH-1:0] MW_ZERO = {C_MW_WIDTH{1'b0}};

  logic [C_MH_WIDTH-1:0] row_q, row_d;
  logic [C_MW_WIDTH-1:0] col_q, col_d;
  logic                  col_last_s;
  logic                  row_last_s;
  logic                  first_s;

  // Position decode and per-beat framing strobes
  always_comb begin
    col_last_s = (col_q == (m_width - MW_ONE));
    row_last_s = (row_q == (m_height - MH_ONE));
    first_s    = (row_q == MH_ZERO) && (col_q == MW_ZERO);
    frame_last = beat && col_last_s && row_last_s;
    sof_err    = beat && (tuser != first_s);
    eol_err    = beat && (tlast != col_last_s);
  end

  // Row/column counter next state; counting by increment avoids a multiplier
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (start) begin
      row_d = MH_ZERO;
      col_d = MW_ZERO;
    end else if (beat) begin
      if (col_last_s) begin
        col_d = MW_ZERO;
        row_d = row_last_s ? MH_ZERO : (row_q + MH_ONE);
      end else begin
        col_d = col_q + MW_ONE;
      end
    end else begin
      row_d = row_q;
      col_d = col_q;
    end
  end

  // Row/column counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      row_q <= MH_ZERO;
      col_q <= MW_ZERO;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

endmodule

// File: rtl/axis_scaler_ctl.sv
// -----------------------------------------------------------------------------
// axis_scaler_ctl
// Frame-level controller for axis_scaler. Software geometry is captured in
// shadow registers and copied to the active outputs only when a frame sync is
// accepted. The external sync is gated into a one-cycle fsync, and the scaler
// output handshake is monitored for frame completion, SOF/EOL errors, overruns
// and (optionally) stalls.
// Optional feature macro: AXIS_SCALER_CTL_TIMEOUT_EN enables the stall
// watchdog; without it err_timeout is constant 0 and timeout_limit is unused.
// Ports:
//   clk, reset                       : clock, synchronous active-high reset
//   enable                           : run request (low = stop after frame)
//   cfg_update, cfg_*                : shadow geometry write
//   clr_err                          : clear sticky error flags
//   timeout_limit                    : stall cycles tolerated in RUN
//   ext_fsync                        : raw frame sync pulse
//   m_axis_tvalid/tready/tuser/tlast : monitored scaler output
//   fsync                            : gated sync to the scaler
//   s_height/s_width/m_height/m_width: active geometry
//   busy                             : controller is in RUN
//   frm_cnt                          : completed frame counter (wraps)
//   err_sof/err_eol/err_overrun/err_timeout/cfg_invalid : sticky flags
// -----------------------------------------------------------------------------
module axis_scaler_ctl
  import axis_scaler_pkg::*;
#(
  parameter int unsigned C_SH_WIDTH      = C_SH_WIDTH_DEF,
  parameter int unsigned C_SW_WIDTH      = C_SW_WIDTH_DEF,
  parameter int unsigned C_MH_WIDTH      = C_MH_WIDTH_DEF,
  parameter int unsigned C_MW_WIDTH      = C_MW_WIDTH_DEF,
  parameter int unsigned C_FRMCNT_WIDTH  = C_FRMCNT_WIDTH_DEF,
  parameter int unsigned C_TIMEOUT_WIDTH = C_TIMEOUT_WIDTH_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       cfg_update,
  input  logic [C_SH_WIDTH-1:0]      cfg_s_height,
  input  logic [C_SW_WIDTH-1:0]      cfg_s_width,
  input  logic [C_MH_WIDTH-1:0]      cfg_m_height,
  input  logic [C_MW_WIDTH-1:0]      cfg_m_width,
  input  logic                       clr_err,
  input  logic [C_TIMEOUT_WIDTH-1:0] timeout_limit,
  input  logic                       ext_fsync,
  input  logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  input  logic                       m_axis_tuser,
  input  logic                       m_axis_tlast,
  output logic                       fsync,
  output logic [C_SH_WIDTH-1:0]      s_height,
  output logic [C_SW_WIDTH-1:0]      s_width,
  output logic [C_MH_WIDTH-1:0]      m_height,
  output logic [C_MW_WIDTH-1:0]      m_width,
  output logic                       busy,
  output logic [C_FRMCNT_WIDTH-1:0]  frm_cnt,
  output logic                       err_sof,
  output logic                       err_eol,
  output logic                       err_overrun,
  output logic                       err_timeout,
  output logic                       cfg_invalid
);

  localparam logic [C_FRMCNT_WIDTH-1:0] FRM_ONE = {{(C_FRMCNT_WIDTH-1){1'b0}}, 1'b1};

  scaler_ctl_state_t state_q, state_d;

  logic [C_SH_WIDTH-1:0] sh_s_height_q, sh_s_height_d;
  logic [C_SW_WIDTH-1:0] sh_s_width_q,  sh_s_width_d;
  logic [C_MH_WIDTH-1:0] sh_m_height_q, sh_m_height_d;
  logic [C_MW_WIDTH-1:0] sh_m_width_q,  sh_m_width_d;
  logic                  have_cfg_q,    have_cfg_d;

  logic [C_SH_WIDTH-1:0] act_s_height_q, act_s_height_d;
  logic [C_SW_WIDTH-1:0] act_s_width_q,  act_s_width_d;
  logic [C_MH_WIDTH-1:0] act_m_height_q, act_m_height_d;
  logic [C_MW_WIDTH-1:0] act_m_width_q,  act_m_width_d;

  logic                      fsync_q,   fsync_d;
  logic [C_FRMCNT_WIDTH-1:0] frm_cnt_q, frm_cnt_d;
  logic [ERR_NUM-1:0]        err_q,     err_d;
  logic [ERR_NUM-1:0]        err_set_s;

  logic cfg_valid_s;
  logic cfg_take_s;
  logic beat_s;
  logic apply_s;
  logic frame_last_s;
  logic sof_err_s;
  logic eol_err_s;
  logic wd_expire_s;

  // Request qualification and handshake decode
  always_comb begin
    cfg_valid_s = (|cfg_s_height) && (|cfg_s_width) && (|cfg_m_height) && (|cfg_m_width);
    cfg_take_s  = cfg_update && cfg_valid_s;
    beat_s      = (state_q == RUN) && m_axis_tvalid && m_axis_tready;
    apply_s     = (state_q == WAIT_SYNC) && enable && ext_fsync;
  end

  axis_frame_checker #(
    .C_MH_WIDTH (C_MH_WIDTH),
    .C_MW_WIDTH (C_MW_WIDTH)
  ) u_frame_checker (
    .clk        (clk),
    .reset      (reset),
    .start      (apply_s),
    .beat       (beat_s),
    .tuser      (m_axis_tuser),
    .tlast      (m_axis_tlast),
    .m_height   (act_m_height_q),
    .m_width    (act_m_width_q),
    .frame_last (frame_last_s),
    .sof_err    (sof_err_s),
    .eol_err    (eol_err_s)
  );

`ifdef AXIS_SCALER_CTL_TIMEOUT_EN
  localparam logic [C_TIMEOUT_WIDTH-1:0] WD_ONE  = {{(C_TIMEOUT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [C_TIMEOUT_WIDTH-1:0] WD_ZERO = {C_TIMEOUT_WIDTH{1'b0}};

  logic [C_TIMEOUT_WIDTH-1:0] wd_q, wd_d;
  logic [C_TIMEOUT_WIDTH-1:0] wd_inc_s;

  // Stall watchdog: counts beat-less RUN cycles; a beat wins over expiry
  always_comb begin
    wd_inc_s    = wd_q + WD_ONE;
    wd_expire_s = 1'b0;
    if (state_q != RUN) begin
      wd_d = WD_ZERO;
    end else if (beat_s) begin
      wd_d = WD_ZERO;
    end else begin
      wd_d = wd_inc_s;
      if ((|timeout_limit) && (wd_inc_s >= timeout_limit)) begin
        wd_expire_s = 1'b1;
      end else begin
        wd_expire_s = 1'b0;
      end
    end
  end

  // Stall watchdog register
  always_ff @(posedge clk) begin
    if (reset) begin
      wd_q <= WD_ZERO;
    end else begin
      wd_q <= wd_d;
    end
  end
`else
  logic unused_timeout_s;

  assign wd_expire_s      = 1'b0;
  assign unused_timeout_s = ^timeout_limit;
`endif

  // Pending shadow: only fully nonzero geometry is accepted
  always_comb begin
    if (cfg_take_s) begin
      sh_s_height_d = cfg_s_height;
      sh_s_width_d  = cfg_s_width;
      sh_m_height_d = cfg_m_height;
      sh_m_width_d  = cfg_m_width;
      have_cfg_d    = 1'b1;
    end else begin
      sh_s_height_d = sh_s_height_q;
      sh_s_width_d  = sh_s_width_q;
      sh_m_height_d = sh_m_height_q;
      sh_m_width_d  = sh_m_width_q;
      have_cfg_d    = have_cfg_q;
    end
  end

  // FSM next state, fsync generation, geometry apply and frame counting
  always_comb begin
    state_d        = state_q;
    fsync_d        = 1'b0;
    act_s_height_d = act_s_height_q;
    act_s_width_d  = act_s_width_q;
    act_m_height_d = act_m_height_q;
    act_m_width_d  = act_m_width_q;
    frm_cnt_d      = frm_cnt_q;
    case (state_q)
      IDLE: begin
        if (enable && have_cfg_q) begin
          state_d = WAIT_SYNC;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT_SYNC: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (ext_fsync) begin
          state_d = RUN;
          fsync_d = 1'b1;
          // A valid write coinciding with the sync goes straight to the outputs
          if (cfg_take_s) begin
            act_s_height_d = cfg_s_height;
            act_s_width_d  = cfg_s_width;
            act_m_height_d = cfg_m_height;
            act_m_width_d  = cfg_m_width;
          end else begin
            act_s_height_d = sh_s_height_q;
            act_s_width_d  = sh_s_width_q;
            act_m_height_d = sh_m_height_q;
            act_m_width_d  = sh_m_width_q;
          end
        end else begin
          state_d = WAIT_SYNC;
        end
      end
      RUN: begin
        if (frame_last_s) begin
          frm_cnt_d = frm_cnt_q + FRM_ONE;
          state_d   = enable ? WAIT_SYNC : IDLE;
        end else if (wd_expire_s) begin
          state_d = WAIT_SYNC;
        end else begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Sticky error flags; a new set condition overrides a simultaneous clear
  always_comb begin
    err_set_s              = {ERR_NUM{1'b0}};
    err_set_s[ERR_SOF]     = sof_err_s;
    err_set_s[ERR_EOL]     = eol_err_s;
    err_set_s[ERR_OVERRUN] = (state_q == RUN) && ext_fsync;
    err_set_s[ERR_TIMEOUT] = wd_expire_s;
    err_set_s[ERR_CFG]     = cfg_update && !cfg_valid_s;
    err_d = err_set_s | (clr_err ? {ERR_NUM{1'b0}} : err_q);
  end

  // Controller state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      sh_s_height_q  <= {C_SH_WIDTH{1'b0}};
      sh_s_width_q   <= {C_SW_WIDTH{1'b0}};
      sh_m_height_q  <= {C_MH_WIDTH{1'b0}};
      sh_m_width_q   <= {C_MW_WIDTH{1'b0}};
      have_cfg_q     <= 1'b0;
      act_s_height_q <= {C_SH_WIDTH{1'b0}};
      act_s_width_q  <= {C_SW_WIDTH{1'b0}};
      act_m_height_q <= {C_MH_WIDTH{1'b0}};
      act_m_width_q  <= {C_MW_WIDTH{1'b0}};
      fsync_q        <= 1'b0;
      frm_cnt_q      <= {C_FRMCNT_WIDTH{1'b0}};
      err_q          <= {ERR_NUM{1'b0}};
    end else begin
      state_q        <= state_d;
      sh_s_height_q  <= sh_s_height_d;
      sh_s_width_q   <= sh_s_width_d;
      sh_m_height_q  <= sh_m_height_d;
      sh_m_width_q   <= sh_m_width_d;
      have_cfg_q     <= have_cfg_d;
      act_s_height_q <= act_s_height_d;
      act_s_width_q  <= act_s_width_d;
      act_m_height_q <= act_m_height_d;
      act_m_width_q  <= act_m_width_d;
      fsync_q        <= fsync_d;
      frm_cnt_q      <= frm_cnt_d;
      err_q          <= err_d;
    end
  end

  assign fsync       = fsync_q;
  assign s_height    = act_s_height_q;
  assign s_width     = act_s_width_q;
  assign m_height    = act_m_height_q;
  assign m_width     = act_m_width_q;
  assign busy        = (state_q == RUN);
  assign frm_cnt     = frm_cnt_q;
  assign err_sof     = err_q[ERR_SOF];
  assign err_eol     = err_q[ERR_EOL];
  assign err_overrun = err_q[ERR_OVERRUN];
  // Never set when the watchdog is compiled out, so it stays at 0
  assign err_timeout = err_q[ERR_TIMEOUT];
  assign cfg_invalid = err_q[ERR_CFG];

endmodule

// File: tb/tb_axis_scaler_ctl.sv
module tb_axis_scaler_ctl;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        cfg_update;
  logic [11:0] cfg_s_height, cfg_s_width, cfg_m_height, cfg_m_width;
  logic        clr_err;
  logic [23:0] timeout_limit;
  logic        ext_fsync;
  logic        tvalid, tready, tuser, tlast;
  logic        fsync;
  logic [11:0] s_height, s_width, m_height, m_width;
  logic        busy;
  logic [15:0] frm_cnt;
  logic        err_sof, err_eol, err_overrun, err_timeout, cfg_invalid;

  int checks = 0;
  int errors = 0;
  int exp_frm = 0;

  always #5 clk = ~clk;

  axis_scaler_ctl dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .cfg_update    (cfg_update),
    .cfg_s_height  (cfg_s_height),
    .cfg_s_width   (cfg_s_width),
    .cfg_m_height  (cfg_m_height),
    .cfg_m_width   (cfg_m_width),
    .clr_err       (clr_err),
    .timeout_limit (timeout_limit),
    .ext_fsync     (ext_fsync),
    .m_axis_tvalid (tvalid),
    .m_axis_tready (tready),
    .m_axis_tuser  (tuser),
    .m_axis_tlast  (tlast),
    .fsync         (fsync),
    .s_height      (s_height),
    .s_width       (s_width),
    .m_height      (m_height),
    .m_width       (m_width),
    .busy          (busy),
    .frm_cnt       (frm_cnt),
    .err_sof       (err_sof),
    .err_eol       (err_eol),
    .err_overrun   (err_overrun),
    .err_timeout   (err_timeout),
    .cfg_invalid   (cfg_invalid)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input int sh, input int sw, input int mh, input int mw);
    cfg_s_height = 12'(sh);
    cfg_s_width  = 12'(sw);
    cfg_m_height = 12'(mh);
    cfg_m_width  = 12'(mw);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    exp_frm = 0;
  endtask

  // One accepted beat after 0..2 stall cycles; clr/fs only on the accepted cycle
  task automatic send_beat(input logic user, input logic last, input logic clr, input logic fs);
    int nw;
    nw = int'($urandom_range(0, 2));
    for (int k = 0; k < nw; k++) begin
      tvalid = 1'($urandom_range(0, 1));
      tready = ~tvalid;
      tuser  = user;
      tlast  = last;
      tick();
    end
    tvalid    = 1'b1;
    tready    = 1'b1;
    tuser     = user;
    tlast     = last;
    clr_err   = clr;
    ext_fsync = fs;
    tick();
    tvalid    = 1'b0;
    tready    = 1'b0;
    tuser     = 1'b0;
    tlast     = 1'b0;
    clr_err   = 1'b0;
    ext_fsync = 1'b0;
  endtask

  // Full frame; bad/clr flip tlast at that beat index, clr also pulses clr_err,
  // fs pulses ext_fsync at that beat index (-1 disables each)
  task automatic frame(input int h, input int w, input int bad, input int clr, input int fs);
    int   idx;
    logic u;
    logic l;
    idx = 0;
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        u = (r == 0) && (c == 0);
        l = (c == w - 1);
        if (idx == bad || idx == clr) l = ~l;
        send_beat(u, l, idx == clr, idx == fs);
        if (idx == bad) chk("eol_set", 32'(err_eol), 32'd1);
        if (idx == clr) chk("eol_set_wins_clr", 32'(err_eol), 32'd1);
        if (idx == fs) begin
          chk("overrun_set", 32'(err_overrun), 32'd1);
          chk("overrun_no_fsync", 32'(fsync), 32'd0);
        end
        idx++;
      end
    end
    exp_frm++;
    chk("frame_busy_low", 32'(busy), 32'd0);
    chk("frame_cnt", 32'(frm_cnt), 32'(exp_frm));
  endtask

  task automatic pulse_sync();
    ext_fsync = 1'b1;
    tick();
    ext_fsync = 1'b0;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; cfg_update = 1'b0; clr_err = 1'b0;
    timeout_limit = 24'd100; ext_fsync = 1'b0;
    tvalid = 1'b0; tready = 1'b0; tuser = 1'b0; tlast = 1'b0;
    set_cfg(0, 0, 0, 0);
    do_reset();

    // Reset state
    chk("rst_fsync", 32'(fsync), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_frm", 32'(frm_cnt), 32'd0);
    chk("rst_mw", 32'(m_width), 32'd0);
    chk("rst_errs", 32'({err_sof, err_eol, err_overrun, err_timeout, cfg_invalid}), 32'd0);

    // Basic frame 10x10 -> 5x5
    set_cfg(10, 10, 5, 5);
    cfg_update = 1'b1; enable = 1'b1;
    tick();
    cfg_update = 1'b0;
    chk("pending_not_active", 32'(m_height), 32'd0);
    tick();
    pulse_sync();
    chk("fsync_high", 32'(fsync), 32'd1);
    chk("busy_rise", 32'(busy), 32'd1);
    chk("geom", 32'({s_height, s_width, m_height, m_width}), {12'd10, 12'd10, 12'd5, 12'd5});
    tick();
    chk("fsync_one_cycle", 32'(fsync), 32'd0);
    frame(5, 5, -1, -1, -1);
    chk("f1_errs", 32'({err_sof, err_eol, err_overrun, err_timeout, cfg_invalid}), 32'd0);

    // Shadow write during RUN does not touch active geometry
    pulse_sync();
    set_cfg(10, 10, 4, 4);
    cfg_update = 1'b1;
    tick();
    cfg_update = 1'b0;
    chk("run_shadow_mh", 32'(m_height), 32'd5);
    frame(5, 5, -1, -1, -1);
    chk("after_frame_mw", 32'(m_width), 32'd5);
    pulse_sync();
    chk("applied_4x4", 32'({m_height, m_width}), {8'd0, 12'd4, 12'd4});
    frame(4, 4, -1, -1, -1);

    // Bypass: valid write together with the applying sync
    set_cfg(9, 8, 5, 5);
    cfg_update = 1'b1; ext_fsync = 1'b1;
    tick();
    cfg_update = 1'b0; ext_fsync = 1'b0;
    chk("bypass_geom", 32'({s_height, s_width}), {8'd0, 12'd9, 12'd8});
    chk("bypass_mw", 32'(m_width), 32'd5);
    // tlast at col 3 of row 0, then another bad tlast together with clr_err
    frame(5, 5, 3, 8, -1);
    chk("sof_clean", 32'(err_sof), 32'd0);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("eol_cleared", 32'(err_eol), 32'd0);

    // Overrun mid-frame, then on the last beat
    pulse_sync();
    frame(5, 5, -1, -1, 10);
    pulse_sync();
    frame(5, 5, -1, -1, 24);
    tick();
    chk("last_beat_sync_not_applied", 32'(busy), 32'd0);
    chk("last_beat_sync_no_fsync", 32'(fsync), 32'd0);

    // Invalid configuration after reset
    do_reset();
    set_cfg(10, 10, 5, 0);
    cfg_update = 1'b1;
    tick();
    cfg_update = 1'b0;
    chk("cfg_invalid", 32'(cfg_invalid), 32'd1);
    tick();
    tick();
    pulse_sync();
    chk("invalid_no_fsync", 32'(fsync), 32'd0);
    chk("invalid_idle", 32'(dut.state_q), 32'd0);

    // Stall: 3 beats then nothing
    do_reset();
    set_cfg(10, 10, 5, 5);
    cfg_update = 1'b1;
    tick();
    cfg_update = 1'b0;
    tick();
    pulse_sync();
    send_beat(1'b1, 1'b0, 1'b0, 1'b0);
    send_beat(1'b0, 1'b0, 1'b0, 1'b0);
    send_beat(1'b0, 1'b0, 1'b0, 1'b0);
`ifdef AXIS_SCALER_CTL_TIMEOUT_EN
    repeat (99) tick();
    chk("wd_not_yet", 32'(err_timeout), 32'd0);
    chk("wd_still_busy", 32'(busy), 32'd1);
    tick();
    chk("wd_expired", 32'(err_timeout), 32'd1);
    chk("wd_wait_sync", 32'(dut.state_q), 32'd1);
    chk("wd_frm", 32'(frm_cnt), 32'd0);
`else
    repeat (120) tick();
    chk("no_wd_flag", 32'(err_timeout), 32'd0);
    chk("no_wd_busy", 32'(busy), 32'd1);
`endif

    // Reset mid-frame / after stall abandons everything silently
    do_reset();
    chk("rst2_busy", 32'(busy), 32'd0);
    chk("rst2_geom", 32'({s_height, m_width}), 32'd0);
    chk("rst2_errs", 32'({err_sof, err_eol, err_overrun, err_timeout, cfg_invalid}), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
